// File: rtl/fnd_scan_drv.sv
// Multiplexed common-anode 7-segment scan driver: one digit per slot, frame-coherent
// snapshot of the inputs, leading-zero blanking, per-digit blink and decimal points.
module fnd_scan_drv #(
  parameter int N_DIG     = 6,
  parameter int SCAN_DIV  = 50000,
  parameter int DEAD      = 4,
  parameter int BLINK_DIV = 250
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6*N_DIG-1:0]   din,
  input  logic                 blank_lz,
  input  logic [N_DIG-1:0]     blink_en,
  input  logic [N_DIG-1:0]     dp_in,
  output logic [7:0]           seg,
  output logic [N_DIG-1:0]     com,
  output logic                 frame
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] PRE_DEAD = PW'(DEAD);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIG - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_DIV - 1);

  logic [PW-1:0]        pre_q, pre_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic                 hide_q, hide_d;
  logic                 frame_q, frame_d;
  logic [7:0]           seg_q, seg_d;
  logic [N_DIG-1:0]     com_q, com_d;

  logic [6*N_DIG-1:0]   din_q;
  logic                 blz_q;
  logic [N_DIG-1:0]     blk_q;
  logic [N_DIG-1:0]     dp_q;

  logic                 tc, wrap;
  logic [5:0]           cur_dig;
  logic                 cur_lz, cur_dp, cur_blk, allz;
  logic [N_DIG-1:0]     lz;

  function automatic logic [7:0] decode(input logic [5:0] v);
    case (v)
      6'd0:    decode = 8'hC0;
      6'd1:    decode = 8'hF9;
      6'd2:    decode = 8'hA4;
      6'd3:    decode = 8'hB0;
      6'd4:    decode = 8'h99;
      6'd5:    decode = 8'h92;
      6'd6:    decode = 8'h82;
      6'd7:    decode = 8'hF8;
      6'd8:    decode = 8'h80;
      6'd9:    decode = 8'h90;
      default: decode = 8'hBF;
    endcase
  endfunction

  // Scan timing: prescaler, digit index, blink frame counter
  always_comb begin
    tc      = (pre_q == PRE_LAST);
    wrap    = tc && (idx_q == IDX_LAST);
    pre_d   = tc ? '0 : pre_q + 1'b1;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    hide_d  = hide_q;
    frame_d = wrap;
    if (tc) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    if (wrap) begin
      if (bcnt_q == BLK_LAST) begin
        bcnt_d = '0;
        hide_d = ~hide_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q  <= '0;
      idx_q  <= '0;
      bcnt_q <= '0;
      hide_q <= 1'b0;
      din_q  <= '0;
      blz_q  <= 1'b0;
      blk_q  <= '0;
      dp_q   <= '0;
    end else begin
      pre_q  <= pre_d;
      idx_q  <= idx_d;
      bcnt_q <= bcnt_d;
      hide_q <= hide_d;
      // Snapshot shares the edge with the index wrap so each frame starts at digit 0 with fresh data
      if (wrap) begin
        din_q <= din;
        blz_q <= blank_lz;
        blk_q <= blink_en;
        dp_q  <= dp_in;
      end
    end
  end

  // Per-digit attributes of the selected slot; lz[i] set when digits N_DIG-1..i are all zero
  always_comb begin
    cur_dig = '0;
    cur_lz  = 1'b0;
    cur_dp  = 1'b0;
    cur_blk = 1'b0;
    allz    = 1'b1;
    lz      = '0;
    for (int i = N_DIG - 1; i >= 1; i--) begin
      allz  = allz & (din_q[6*i +: 6] == 6'd0);
      lz[i] = allz;
    end
    for (int i = 0; i < N_DIG; i++) begin
      if (idx_q == IW'(i)) begin
        cur_dig = din_q[6*i +: 6];
        cur_lz  = lz[i];
        cur_dp  = dp_q[i];
        cur_blk = blk_q[i];
      end
    end
  end

  // Output stage: dead time first, then decode, blanking, dp and blink in rising priority
  always_comb begin
    seg_d = 8'hFF;
    com_d = '1;
    if (pre_q >= PRE_DEAD) begin
      for (int i = 0; i < N_DIG; i++) com_d[i] = (idx_q != IW'(i));
      seg_d = decode(cur_dig);
      if (blz_q && cur_lz) seg_d[6:0] = 7'h7F;
      if (cur_dp)          seg_d[7]   = 1'b0;
      if (hide_q && cur_blk) seg_d    = 8'hFF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q   <= 8'hFF;
      com_q   <= '1;
      frame_q <= 1'b0;
    end else begin
      seg_q   <= seg_d;
      com_q   <= com_d;
      frame_q <= frame_d;
    end
  end

  assign seg   = seg_q;
  assign com   = com_q;
  assign frame = frame_q;

endmodule
